// File: rtl/mdu.sv
// mdu: iterative RV32M multiply/divide unit, 32 shift-add or restoring-divide steps per op.
// Divide-by-zero and signed overflow skip iteration by preloading the accumulator with the mandated result.
module mdu (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] MDUA,
    input  logic [31:0] MDUB,
    output logic [31:0] MDURes,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic        neg_q, neg_d;
    logic [31:0] m_q, m_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] res_q, res_d;
    logic        done_q, done_d;

    logic        sgn_a, sgn_b, sa, sb, dz, ovf, accept, ge;
    logic [31:0] amag, bmag, dlo, dhalf, dres, fix_res;
    logic [32:0] msum, pr;
    logic [63:0] step, prod;

    always_comb begin
        sgn_a   = MDUOp[2] ? ~MDUOp[0] : (MDUOp[1] ^ MDUOp[0]);
        sgn_b   = MDUOp[2] ? ~MDUOp[0] : (MDUOp[1:0] == 2'b01);
        sa      = sgn_a & MDUA[31];
        sb      = sgn_b & MDUB[31];
        amag    = sa ? -MDUA : MDUA;
        bmag    = sb ? -MDUB : MDUB;
        dz      = MDUOp[2] & (MDUB == 32'd0);
        ovf     = MDUOp[2] & ~MDUOp[0] & (MDUA == 32'h8000_0000) & (MDUB == 32'hFFFF_FFFF);
        accept  = (state_q == IDLE) & ~done_q & start;
        // m_q holds the multiplicand for products and the divisor for divides
        msum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, m_q} : 33'd0);
        pr      = acc_q[63:31];
        ge      = pr >= {1'b0, m_q};
        dlo     = pr[31:0] - m_q;
        step    = op_q[2] ? (ge ? {dlo, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0})
                          : {msum, acc_q[31:1]};
        prod    = neg_q ? -acc_q : acc_q;
        dhalf   = op_q[1] ? acc_q[63:32] : acc_q[31:0];
        dres    = neg_q ? -dhalf : dhalf;
        fix_res = op_q[2] ? dres : ((op_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32]);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        m_d     = m_q;
        acc_d   = acc_q;
        res_d   = res_q;
        done_d  = 1'b0;
        if (accept) begin
            state_d = (dz | ovf) ? FIX : ITER;
            cnt_d   = 6'd0;
            op_d    = MDUOp;
            m_d     = MDUOp[2] ? bmag : amag;
            neg_d   = ~(dz | ovf) & ((MDUOp[2] & MDUOp[1]) ? sa : (sa ^ sb));
            acc_d   = dz  ? {MDUA, 32'hFFFF_FFFF}
                    : ovf ? {32'd0, 32'h8000_0000}
                    :       {32'd0, MDUOp[2] ? amag : bmag};
        end else if (state_q == ITER) begin
            acc_d   = step;
            cnt_d   = (cnt_q == 6'd31) ? 6'd0 : cnt_q + 6'd1;
            state_d = (cnt_q == 6'd31) ? FIX : ITER;
        end else if (state_q == FIX) begin
            res_d   = fix_res;
            done_d  = 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            op_q    <= 3'd0;
            neg_q   <= 1'b0;
            m_q     <= 32'd0;
            acc_q   <= 64'd0;
            res_q   <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    assign MDURes = res_q;
    assign busy   = state_q != IDLE;
    assign done   = done_q;
endmodule
